// File: rtl/cory_demux4_pkg.sv
// Shared constants and helpers for the tagged 4-way return demux.
// Statistics are enabled by defining CORY_DEMUX4_TAGGED_STAT_EN.
package cory_demux4_pkg;

    localparam int TAG_W  = 2;
    localparam int NUM_CH = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // The 33-bit sum keeps a carry out of bit 31 from looking like a small value.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

endpackage

// File: rtl/_cory_demux4_fifo.sv
// D-deep, W-wide FIFO with valid/ready on both sides. The head is read
// straight from the storage registers, so there is no input-to-output path.
module _cory_demux4_fifo
    import cory_demux4_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_v,
    input  logic [W-1:0] i_d,
    output logic         o_r,
    output logic         o_v,
    output logic [W-1:0] o_d,
    input  logic         i_r
);

    localparam int PW = ptr_width(D);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign full  = (wr_q ^ rd_q) == PW'(D);
    assign empty = (wr_q == rd_q);
    assign o_r   = !full;
    assign o_v   = !empty;
    assign o_d   = mem_q[rd_q[AW-1:0]];
    assign push  = i_v && !full;
    assign pop   = !empty && i_r;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = i_d;
            wr_d                = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
    end

    // Storage needs no reset; clearing the pointers discards buffered beats.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/cory_demux4_tagged.sv
// Routes a tagged stream back to 4 channels, each with a private FIFO.
// Define CORY_DEMUX4_TAGGED_STAT_EN for saturating weighted beat counters.
module cory_demux4_tagged
    import cory_demux4_pkg::*;
#(
    parameter int N = 8,
    parameter int L = 4,
    parameter int B = 8,
    parameter int D = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_a_v,
    input  logic [N-1:0]     i_a_d,
    input  logic [TAG_W-1:0] i_a_s,
    input  logic [L-1:0]     i_a_wt,
    output logic             o_a_r,
    output logic             o_z0_v,
    output logic [N-1:0]     o_z0_d,
    input  logic             i_z0_r,
    output logic             o_z1_v,
    output logic [N-1:0]     o_z1_d,
    input  logic             i_z1_r,
    output logic             o_z2_v,
    output logic [N-1:0]     o_z2_d,
    input  logic             i_z2_r,
    output logic             o_z3_v,
    output logic [N-1:0]     o_z3_d,
    input  logic             i_z3_r,
    output logic [B:0]       o_st_cnt0,
    output logic [B:0]       o_st_cnt1,
    output logic [B:0]       o_st_cnt2,
    output logic [B:0]       o_st_cnt3,
    input  logic             i_st_clr,
    output logic             o_busy
);

`ifdef CORY_DEMUX4_TAGGED_STAT_EN
    localparam int FW = N + L;
`else
    localparam int FW = N;
`endif

    logic [NUM_CH-1:0] ch_push_v;
    logic [NUM_CH-1:0] ch_r;
    logic [NUM_CH-1:0] ch_v;
    logic [NUM_CH-1:0] ch_rdy_in;
    logic [FW-1:0]     ch_d [NUM_CH];
    logic [FW-1:0]     in_word;

    assign ch_rdy_in = {i_z3_r, i_z2_r, i_z1_r, i_z0_r};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_push_v[k] = i_a_v && (i_a_s == TAG_W'(k));

        _cory_demux4_fifo #(
            .W (FW),
            .D (D)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .i_v   (ch_push_v[k]),
            .i_d   (in_word),
            .o_r   (ch_r[k]),
            .o_v   (ch_v[k]),
            .o_d   (ch_d[k]),
            .i_r   (ch_rdy_in[k])
        );
    end

    // Ready only reflects the tagged channel, so other channels never stall us.
    assign o_a_r  = ch_r[i_a_s];
    assign o_busy = |ch_v;

    assign o_z0_v = ch_v[0];
    assign o_z1_v = ch_v[1];
    assign o_z2_v = ch_v[2];
    assign o_z3_v = ch_v[3];
    assign o_z0_d = ch_d[0][N-1:0];
    assign o_z1_d = ch_d[1][N-1:0];
    assign o_z2_d = ch_d[2][N-1:0];
    assign o_z3_d = ch_d[3][N-1:0];

`ifdef CORY_DEMUX4_TAGGED_STAT_EN
    localparam int          CW      = B + 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);

    logic [NUM_CH-1:0] ch_pop;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];

    assign in_word = {i_a_wt, i_a_d};
    assign ch_pop  = ch_v & ch_rdy_in;

    // The weight travels with the beat and is charged when the beat leaves.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (i_st_clr) begin
                cnt_d[k] = '0;
            end else if (ch_pop[k]) begin
                cnt_d[k] = CW'(sat_add(32'(cnt_q[k]),
                                       32'(ch_d[k][FW-1:N]) + 32'd1,
                                       CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_st_cnt0 = cnt_q[0];
    assign o_st_cnt1 = cnt_q[1];
    assign o_st_cnt2 = cnt_q[2];
    assign o_st_cnt3 = cnt_q[3];
`else
    logic unused_stat;

    assign in_word     = i_a_d;
    assign o_st_cnt0   = '0;
    assign o_st_cnt1   = '0;
    assign o_st_cnt2   = '0;
    assign o_st_cnt3   = '0;
    assign unused_stat = ^{i_st_clr, i_a_wt};
`endif

endmodule
